prog_ctr_seq: RTL and testbench
===============================

Name: prog_ctr_seq

Overview:
Program-counter sequencer; consumes the ALU `branch` decision and produces the instruction-memory address each cycle.
- Holds a small programmable branch-target lookup table (LUT) indexed by the instruction's target field.
- Provides start/halt control, a stall hold, a one-cycle flush pulse after each taken branch, and a retired-instruction counter.
- Sits between the ALU branch output and the instruction ROM address input in the top level.

Parameters:
PC_W, 10, program counter width in bits
IDX_W, 5, branch-target LUT index width (2**IDX_W entries, each PC_W bits)
START_ADDR, 0, PC value loaded on reset and on restart

Ports:
Clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
Start  input  1  begin/restart execution (honoured in IDLE and HALTED)
Halt_req  input  1  stop execution (honoured in RUN)
Stall  input  1  hold PC this cycle (RUN only)
Branch  input  1  taken-branch decision from ALU, valid the same cycle as Target_idx
Target_idx  input  IDX_W  LUT index of the branch target
Lut_wr_en  input  1  LUT write strobe
Lut_wr_idx  input  IDX_W  LUT write index
Lut_wr_data  input  PC_W  LUT write data
Prog_ctr  output  PC_W  current instruction address
Flush  output  1  one-cycle pulse the cycle after a taken branch
Done  output  1  high while in HALTED
Instr_cnt  output  16  retired-instruction count, saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, Prog_ctr=START_ADDR, Flush=0, Done=0, Instr_cnt=0.
  - All LUT entries are set to 0.
  - Reset mid-operation aborts immediately; no pending branch or write survives.
- States: IDLE, RUN, HALTED. All outputs are registered.
- IDLE:
  - Prog_ctr is held.
  - Start=1 -> RUN next cycle with Prog_ctr unchanged, so the first fetch is at START_ADDR.
  - Branch, Stall and Halt_req are ignored.
- RUN, per cycle, priority Halt_req > Stall > Branch > increment:
  - Halt_req=1 -> HALTED next cycle; Prog_ctr held; Instr_cnt not incremented; Flush=0.
  - Stall=1 -> Prog_ctr held; Instr_cnt held; Flush=0. A Branch in the same cycle is dropped; the ALU must re-present it.
  - Branch=1 -> Prog_ctr <= LUT[Target_idx]; Instr_cnt+1; Flush=1 in the next cycle.
  - Otherwise -> Prog_ctr <= Prog_ctr+1 modulo 2**PC_W (all-ones wraps to 0); Instr_cnt+1; Flush=0.
- Flush:
  - High for exactly the one cycle following each taken branch.
  - Back-to-back taken branches keep Flush continuously high.
  - Flush=0 in IDLE and HALTED.
- Instr_cnt saturates at 16'hFFFF and does not wrap.
- HALTED:
  - Done=1 from the first HALTED cycle; Prog_ctr is held.
  - Start=1 -> RUN next cycle with Prog_ctr=START_ADDR, Instr_cnt=0, Done=0.
  - Branch, Stall and Halt_req are ignored.
- LUT:
  - Synchronous write, permitted in any state.
  - When a write and a branch read hit the same index in the same cycle, the branch uses the OLD entry (read-before-write). The new value is visible from the next cycle.
- Latency: a Branch presented in cycle N appears on Prog_ctr in cycle N+1.
- Halt_req and Start both high: in RUN, Halt wins; in IDLE/HALTED, Start wins.

Test Plan:
- Reset then start: release reset, Start=1 for one cycle, run 5 cycles -> Prog_ctr sequence 0,0,1,2,3,4; Instr_cnt=4; Flush=0 throughout.
- Branch and flush: write LUT[3]=0x155; in RUN at Prog_ctr=7 assert Branch=1, Target_idx=3 -> next cycle Prog_ctr=0x155, Flush=1 for one cycle, then 0x156 with Flush=0.
- Same-index hazard: LUT[2]=0x010; in one cycle write LUT[2]=0x020 and branch with Target_idx=2 -> Prog_ctr=0x010. A second branch to index 2 one cycle later -> Prog_ctr=0x020.
- Stall priority: Stall=1 and Branch=1 together at Prog_ctr=0x040 -> Prog_ctr stays 0x040, Instr_cnt unchanged, Flush=0.
- Wrap and saturation:
  - PC_W=10, run from 0x3FE -> 0x3FF, 0x000.
  - Preload the counter near max via a long run -> Instr_cnt holds at 0xFFFF.
- Halt/restart and async reset:
  - Halt_req at Prog_ctr=9 -> Done=1 and Prog_ctr stays 9.
  - Start -> Prog_ctr=0, Instr_cnt=0, Done=0.
  - Drop reset mid-RUN between clock edges -> outputs go to reset values immediately and state is IDLE.

Source files
------------

// File: rtl/prog_ctr_seq_if.sv
// Fetch-side bus of the program-counter sequencer: ALU branch decision,
// run control, branch-target LUT write port and the registered PC outputs.
interface prog_ctr_seq_if #(
    parameter int PC_W  = 10,
    parameter int IDX_W = 5
);
    logic             start;
    logic             halt_req;
    logic             stall;
    logic             branch;
    logic [IDX_W-1:0] target_idx;
    logic             lut_wr_en;
    logic [IDX_W-1:0] lut_wr_idx;
    logic [PC_W-1:0]  lut_wr_data;
    logic [PC_W-1:0]  prog_ctr;
    logic             flush;
    logic             done;
    logic [15:0]      instr_cnt;

    modport master (
        output start, halt_req, stall, branch, target_idx,
               lut_wr_en, lut_wr_idx, lut_wr_data,
        input  prog_ctr, flush, done, instr_cnt
    );

    modport slave (
        input  start, halt_req, stall, branch, target_idx,
               lut_wr_en, lut_wr_idx, lut_wr_data,
        output prog_ctr, flush, done, instr_cnt
    );
endinterface

// File: rtl/prog_ctr_seq.sv
// Program-counter sequencer: turns the ALU branch decision into the next
// instruction-ROM address using a programmable branch-target LUT.
//
// state    | meaning
// S_IDLE   | after reset, PC parked at START_ADDR, waiting for start
// S_RUN    | fetching; halt > stall > branch > increment
// S_HALTED | stopped, done high, start restarts from START_ADDR
module prog_ctr_seq #(
    parameter int              PC_W       = 10,
    parameter int              IDX_W      = 5,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    prog_ctr_seq_if.slave bus
);
    localparam int LUT_N = 1 << IDX_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic            r_flush;
    logic            w_flush_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic [15:0]     r_cnt;
    logic [15:0]     w_cnt_nxt;
    logic [15:0]     w_cnt_inc;
    logic [PC_W-1:0] r_lut [LUT_N];

    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= START_ADDR;
            r_flush <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_flush <= w_flush_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.start)    w_state_nxt = S_RUN;
            S_RUN:    if (bus.halt_req) w_state_nxt = S_HALTED;
            S_HALTED: if (bus.start)    w_state_nxt = S_RUN;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // The LUT read below sees the pre-write entry, giving read-before-write.
    always_comb begin
        w_pc_nxt    = r_pc;
        w_flush_nxt = 1'b0;
        w_done_nxt  = (w_state_nxt == S_HALTED);
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_RUN: begin
                if (!bus.halt_req && !bus.stall) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (bus.branch) begin
                        w_pc_nxt    = r_lut[bus.target_idx];
                        w_flush_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = r_pc + PC_W'(1);
                    end
                end
            end
            S_HALTED: begin
                if (bus.start) begin
                    w_pc_nxt  = START_ADDR;
                    w_cnt_nxt = 16'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LUT_N; i++) r_lut[i] <= '0;
        end else if (bus.lut_wr_en) begin
            r_lut[bus.lut_wr_idx] <= bus.lut_wr_data;
        end
    end

    assign bus.prog_ctr  = r_pc;
    assign bus.flush     = r_flush;
    assign bus.done      = r_done;
    assign bus.instr_cnt = r_cnt;
endmodule

// File: tb/tb_prog_ctr_seq.sv
// Scoreboard bench for prog_ctr_seq: a cycle model queues the expected
// outputs for each driven cycle, which are popped and compared after the edge.
`timescale 1ns/1ps
module tb_prog_ctr_seq;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    typedef struct packed {
        logic [9:0]  pc;
        logic        flush;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         m_st;
    logic [9:0] m_pc;
    logic       m_flush;
    logic       m_done;
    logic [15:0] m_cnt;
    logic [9:0] m_lut [32];

    prog_ctr_seq_if #(.PC_W(10), .IDX_W(5)) bus();

    prog_ctr_seq #(.PC_W(10), .IDX_W(5), .START_ADDR(10'd0)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_st    = 0;
        m_pc    = 10'd0;
        m_flush = 1'b0;
        m_done  = 1'b0;
        m_cnt   = 16'd0;
        for (int i = 0; i < 32; i++) m_lut[i] = 10'd0;
    endtask

    task automatic step(input logic st, input logic hr, input logic sl, input logic br,
                        input logic [4:0] ti, input logic we, input logic [4:0] wi,
                        input logic [9:0] wd);
        exp_t e;
        @(negedge clk);
        bus.start       = st;
        bus.halt_req    = hr;
        bus.stall       = sl;
        bus.branch      = br;
        bus.target_idx  = ti;
        bus.lut_wr_en   = we;
        bus.lut_wr_idx  = wi;
        bus.lut_wr_data = wd;
        m_flush = 1'b0;
        if (m_st == 0) begin
            if (st) m_st = 1;
        end else if (m_st == 1) begin
            if (hr) begin
                m_st = 2;
            end else if (!sl) begin
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (br) begin
                    m_pc    = m_lut[ti];
                    m_flush = 1'b1;
                end else begin
                    m_pc = m_pc + 10'd1;
                end
            end
        end else if (st) begin
            m_st  = 1;
            m_pc  = 10'd0;
            m_cnt = 16'd0;
        end
        m_done = (m_st == 2);
        if (we) m_lut[wi] = wd;
        e.pc = m_pc; e.flush = m_flush; e.done = m_done; e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_pc",    32'(bus.prog_ctr),  32'(e.pc));
        chk("sb_flush", 32'(bus.flush),     32'(e.flush));
        chk("sb_done",  32'(bus.done),      32'(e.done));
        chk("sb_cnt",   32'(bus.instr_cnt), 32'(e.cnt));
    endtask

    task automatic plain(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 5'd0, 0, 5'd0, 10'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.start = 0; bus.halt_req = 0; bus.stall = 0; bus.branch = 0;
        bus.target_idx = '0; bus.lut_wr_en = 0; bus.lut_wr_idx = '0; bus.lut_wr_data = '0;
        model_reset();
        #12;
        chk("rst_pc",    32'(bus.prog_ctr),  32'h0);
        chk("rst_flush", 32'(bus.flush),     32'h0);
        chk("rst_done",  32'(bus.done),      32'h0);
        chk("rst_cnt",   32'(bus.instr_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // idle ignores branch/stall/halt, then start and run
        step(0, 1, 1, 1, 5'd1, 0, 5'd0, 10'd0);
        chk("idle_pc", 32'(bus.prog_ctr), 32'h0);
        step(1, 0, 0, 0, 5'd0, 0, 5'd0, 10'd0);
        chk("first_fetch", 32'(bus.prog_ctr), 32'h0);
        plain(4);
        chk("run_pc4",  32'(bus.prog_ctr),  32'h4);
        chk("run_cnt4", 32'(bus.instr_cnt), 32'h4);

        // branch and flush
        step(0, 0, 0, 0, 5'd0, 1, 5'd3, 10'h155);
        plain(2);
        chk("pre_br_pc", 32'(bus.prog_ctr), 32'h7);
        step(0, 0, 0, 1, 5'd3, 0, 5'd0, 10'd0);
        chk("br_pc",    32'(bus.prog_ctr), 32'h155);
        chk("br_flush", 32'(bus.flush),    32'h1);
        plain(1);
        chk("post_br_pc",    32'(bus.prog_ctr), 32'h156);
        chk("post_br_flush", 32'(bus.flush),    32'h0);

        // same-index read-before-write, back-to-back branches
        step(0, 0, 0, 0, 5'd0, 1, 5'd2, 10'h010);
        step(0, 0, 0, 1, 5'd2, 1, 5'd2, 10'h020);
        chk("hazard_old", 32'(bus.prog_ctr), 32'h010);
        step(0, 0, 0, 1, 5'd2, 0, 5'd0, 10'd0);
        chk("hazard_new", 32'(bus.prog_ctr), 32'h020);
        chk("b2b_flush",  32'(bus.flush),    32'h1);

        // stall beats branch
        step(0, 0, 0, 0, 5'd0, 1, 5'd4, 10'h040);
        step(0, 0, 0, 1, 5'd4, 0, 5'd0, 10'd0);
        step(0, 0, 1, 1, 5'd3, 0, 5'd0, 10'd0);
        chk("stall_pc",    32'(bus.prog_ctr),  32'h040);
        chk("stall_cnt",   32'(bus.instr_cnt), 32'd14);
        chk("stall_flush", 32'(bus.flush),     32'h0);

        // PC wrap
        step(0, 0, 0, 0, 5'd0, 1, 5'd5, 10'h3FE);
        step(0, 0, 0, 1, 5'd5, 0, 5'd0, 10'd0);
        plain(1);
        chk("wrap_3ff", 32'(bus.prog_ctr), 32'h3FF);
        plain(1);
        chk("wrap_000", 32'(bus.prog_ctr), 32'h000);

        // halt (halt beats start in RUN), ignore in HALTED, restart
        step(0, 0, 0, 0, 5'd0, 1, 5'd6, 10'd9);
        step(0, 0, 0, 1, 5'd6, 0, 5'd0, 10'd0);
        step(1, 1, 0, 0, 5'd0, 0, 5'd0, 10'd0);
        chk("halt_done", 32'(bus.done),     32'h1);
        chk("halt_pc",   32'(bus.prog_ctr), 32'h9);
        step(0, 1, 1, 1, 5'd3, 0, 5'd0, 10'd0);
        chk("halted_pc", 32'(bus.prog_ctr), 32'h9);
        step(1, 1, 0, 0, 5'd0, 0, 5'd0, 10'd0);
        chk("restart_pc",   32'(bus.prog_ctr),  32'h0);
        chk("restart_cnt",  32'(bus.instr_cnt), 32'h0);
        chk("restart_done", 32'(bus.done),      32'h0);

        // counter saturation
        plain(65540);
        chk("sat_cnt", 32'(bus.instr_cnt), 32'hFFFF);
        plain(1);
        chk("sat_hold", 32'(bus.instr_cnt), 32'hFFFF);

        // async reset mid-RUN with a write and branch in flight
        @(negedge clk);
        bus.branch = 1; bus.target_idx = 5'd3;
        bus.lut_wr_en = 1; bus.lut_wr_idx = 5'd7; bus.lut_wr_data = 10'h123;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc",    32'(bus.prog_ctr),  32'h0);
        chk("arst_flush", 32'(bus.flush),     32'h0);
        chk("arst_done",  32'(bus.done),      32'h0);
        chk("arst_cnt",   32'(bus.instr_cnt), 32'h0);
        model_reset();
        @(negedge clk);
        bus.branch = 0; bus.lut_wr_en = 0;
        rst_n = 1'b1;
        step(0, 0, 0, 1, 5'd7, 0, 5'd0, 10'd0);
        chk("arst_idle_pc", 32'(bus.prog_ctr), 32'h0);
        step(1, 0, 0, 0, 5'd0, 0, 5'd0, 10'd0);
        step(0, 0, 0, 1, 5'd3, 0, 5'd0, 10'd0);
        chk("lut3_cleared", 32'(bus.prog_ctr), 32'h0);
        step(0, 0, 0, 1, 5'd7, 0, 5'd0, 10'd0);
        chk("lut7_no_write", 32'(bus.prog_ctr), 32'h0);

        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
